// File: rtl/jtbubl_scan2x_pkg.sv
// Shared constants for the jtbubl video line doubler.
// Holds the default line geometry, the layout of the 13-bit word kept in the
// line buffer ({LHBL, red, green, blue}), the scanline dimming encodings and
// the start-up state type used by the scan converter.
package jtbubl_scan2x_pkg;

  localparam int unsigned SCAN2X_HLEN = 384;   // default buffer depth per bank
  localparam logic [8:0]  SCAN2X_HSW2 = 9'd28; // default output HS width

  // Line buffer word layout
  localparam int unsigned WORD_W  = 13;
  localparam int unsigned W_LHBL  = 12;
  localparam int unsigned W_RED   = 8;
  localparam int unsigned W_GREEN = 4;
  localparam int unsigned W_BLUE  = 0;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_25  = 2'd1,
    SL_50  = 2'd2,
    SL_75  = 2'd3
  } sl_mode_e;

  // Output stays blanked until a complete line has been captured after reset
  typedef enum logic [1:0] {
    ST_WAIT0 = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_RUN   = 2'd2
  } scan_st_e;

  function automatic logic [3:0] sl_dim(input logic [3:0] c, input sl_mode_e m);
    logic [3:0] r;
    case (m)
      SL_25:   r = c - (c >> 2);
      SL_50:   r = c >> 1;
      SL_75:   r = c >> 2;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jtbubl_scan2x_buf.sv
// Ping-pong line buffer: simple dual-port RAM of 2*HLEN words.
// Bank b occupies words [b*HLEN, b*HLEN+HLEN-1].
//   clk      system clock
//   pxl_cen  write enable strobe; writes wr_data at (wr_bank, wr_addr)
//   pxl2_cen read strobe; registers the word at (rd_bank, rd_addr) to rd_data
module jtbubl_scan2x_buf #(
  parameter int unsigned HLEN = 384,
  parameter int unsigned AW   = 9,
  parameter int unsigned DW   = 13
) (
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          pxl2_cen,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam logic [AW:0] BANK_OFS = (AW+1)'(HLEN);

  logic [DW-1:0] mem [2*HLEN];
  logic [AW:0]   wr_idx;
  logic [AW:0]   rd_idx;

  always_comb begin
    wr_idx = {1'b0, wr_addr} + (wr_bank ? BANK_OFS : '0);
    rd_idx = {1'b0, rd_addr} + (rd_bank ? BANK_OFS : '0);
  end

  always_ff @(posedge clk) begin
    if (pxl_cen) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (pxl2_cen) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/jtbubl_scan2x.sv
// Line-doubling scan converter. Each input line (pxl_cen rate) is written to
// one bank of a ping-pong buffer while the previous line is replayed twice
// from the other bank at pxl2_cen, with optional dimming of the second replay.
//   clk, rst            system clock, synchronous active-high reset
//   pxl_cen, pxl2_cen   input / output pixel enables
//   sl_mode             scanline dimming (off, 25%, 50%, 75%)
//   red/green/blue, LHBL, LVBL, HS, VS   input video
//   x2_red/green/blue, x2_HS, x2_VS, x2_LHBL, x2_LVBL   doubled-rate video
module jtbubl_scan2x
  import jtbubl_scan2x_pkg::*;
#(
  parameter int unsigned HLEN = SCAN2X_HLEN,
  parameter logic [8:0]  HSW2 = SCAN2X_HSW2,
  parameter int unsigned AW   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       pxl2_cen,
  input  logic [1:0] sl_mode,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic       HS,
  input  logic       VS,
  output logic [3:0] x2_red,
  output logic [3:0] x2_green,
  output logic [3:0] x2_blue,
  output logic       x2_HS,
  output logic       x2_VS,
  output logic       x2_LHBL,
  output logic       x2_LVBL
);

  localparam logic [AW-1:0] LAST    = AW'(HLEN - 1);
  localparam logic [AW:0]   LEN_MAX = (AW+1)'(HLEN);
  localparam logic [AW-1:0] HSW2_W  = AW'(HSW2);
  localparam logic [AW-1:0] MIN_LEN = AW'(15);

  scan_st_e st, st_nx;

  logic              hs_l, hs_rise;
  logic              wr_bank;
  logic [AW-1:0]     wr_addr;
  logic [AW:0]       line_len;
  logic              lvbl_l, vs_l;
  logic [AW-1:0]     rd_addr;
  logic              pass, done, rd_end;
  logic [WORD_W-1:0] wr_word, rd_word;

  // Control aligned with the registered buffer read
  logic run_d, done_d, pass_d, hs_d, lvbl_d, vs_d;

  always_comb begin
    hs_rise = pxl_cen & HS & ~hs_l;
    rd_end  = ({1'b0, rd_addr} == line_len - 1'b1);
    wr_word = {LHBL, red, green, blue};
  end

  always_ff @(posedge clk) begin
    if (rst) st <= ST_WAIT0;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    if (hs_rise) begin
      case (st)
        ST_WAIT0: st_nx = ST_WAIT1;
        default:  st_nx = ST_RUN;
      endcase
    end
  end

  // Write side
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_l     <= 1'b0;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      line_len <= LEN_MAX;
      lvbl_l   <= 1'b0;
      vs_l     <= 1'b0;
    end else if (pxl_cen) begin
      hs_l <= HS;
      if (hs_rise) begin
        // short HS-to-HS intervals are glitches and keep the old length
        if (wr_addr >= MIN_LEN) line_len <= {1'b0, wr_addr} + 1'b1;
        wr_addr <= '0;
        wr_bank <= ~wr_bank;
        lvbl_l  <= LVBL;
        vs_l    <= VS;
      end else if (wr_addr != LAST) begin
        wr_addr <= wr_addr + 1'b1;
      end
    end
  end

  // Read side; HS rise restarts the replay and wins over the end-of-line wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
      pass    <= 1'b0;
      done    <= 1'b0;
      run_d   <= 1'b0;
      done_d  <= 1'b0;
      pass_d  <= 1'b0;
      hs_d    <= 1'b0;
      lvbl_d  <= 1'b0;
      vs_d    <= 1'b0;
    end else begin
      if (pxl2_cen) begin
        run_d  <= (st == ST_RUN);
        done_d <= done;
        pass_d <= pass;
        hs_d   <= (rd_addr < HSW2_W);
        lvbl_d <= lvbl_l;
        vs_d   <= vs_l;
      end
      if (hs_rise) begin
        rd_addr <= '0;
        pass    <= 1'b0;
        done    <= 1'b0;
      end else if (pxl2_cen) begin
        if (rd_end) begin
          if (pass) begin
            done <= 1'b1;
          end else begin
            rd_addr <= '0;
            pass    <= 1'b1;
          end
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

  jtbubl_scan2x_buf #(
    .HLEN (HLEN),
    .AW   (AW),
    .DW   (WORD_W)
  ) u_buf (
    .clk      (clk),
    .pxl_cen  (pxl_cen),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (wr_word),
    .pxl2_cen (pxl2_cen),
    .rd_bank  (~wr_bank),
    .rd_addr  (rd_addr),
    .rd_data  (rd_word)
  );

  always_comb begin
    logic     show, pix_on;
    sl_mode_e mode;
    show     = run_d & ~done_d;
    pix_on   = show & rd_word[W_LHBL] & lvbl_d;
    mode     = pass_d ? sl_mode_e'(sl_mode) : SL_OFF;
    x2_red   = pix_on ? sl_dim(rd_word[W_RED   +: 4], mode) : '0;
    x2_green = pix_on ? sl_dim(rd_word[W_GREEN +: 4], mode) : '0;
    x2_blue  = pix_on ? sl_dim(rd_word[W_BLUE  +: 4], mode) : '0;
    x2_LHBL  = show & rd_word[W_LHBL];
    x2_HS    = show & hs_d;
    x2_LVBL  = run_d & lvbl_d;
    x2_VS    = run_d & vs_d;
  end

endmodule
